cpu_bus_master: RTL
===================

Name: cpu_bus_master

Overview:
- Synchronous initiator for the cartridge CPU bus.
- Generates continuous M2 cycles from the system clock and drives cpu_addr, cpu_rw and cpu_dat so a mapper core can be exercised or re-programmed, e.g. for save-state register replay or bench stimulus.
- Accepts one read or write request per M2 cycle over a valid/ready interface and returns read data or write completion.
- Runs idle reads when no request is pending, so M2-clocked logic (IRQ counters, multiplier) keeps advancing.

Parameters:
- T_LO, 14, clk cycles M2 is low per bus cycle (min 2).
- T_HI, 14, clk cycles M2 is high per bus cycle (min 2).
- IDLE_ADDR, 16'hFFFF, address driven on idle read cycles.

Ports:
- clk  in  1  system clock.
- map_rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this clk when req_valid also high.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  16  bus address.
- req_wdat  in  8  write data.
- rsp_valid  out  1  one-clk completion pulse.
- rsp_rdat  out  8  read data (0 for writes).
- m2  out  1  generated M2.
- cpu_addr  out  16  bus address.
- cpu_rw  out  1  bus direction.
- cpu_dat_out  out  8  write data.
- cpu_dat_oe  out  1  data driver enable.
- cpu_dat_in  in  8  data returned by responder.
- cyc_cnt  out  32  count of M2 rising edges since reset, wraps at 2^32.

Behaviour:
- Reset (map_rst sampled high on clk): phase=LO, cnt=0, m2=0, cpu_rw=1, cpu_addr=IDLE_ADDR, cpu_dat_out=0, cpu_dat_oe=0, req_ready=0, rsp_valid=0, rsp_rdat=0, cyc_cnt=0.
- Reset mid-cycle: any in-flight transaction is dropped with no rsp_valid, and the next clk shows the reset values above.
- Phase FSM:
  - LO counts cnt 0..T_LO-1, then goes to HI with cnt=0.
  - HI counts 0..T_HI-1, then goes to LO with cnt=0.
  - m2 is registered and equals (phase==HI).
  - Bus period is T_LO+T_HI clks.
- req_ready is combinational: high only when phase==LO, cnt==0 and map_rst==0. Handshake = req_valid & req_ready, at most one per bus cycle.
- Bus update occurs at LO cnt==0, i.e. the first clk after M2 falls, and is visible from LO cnt==1:
  - On handshake, cpu_addr/cpu_rw/cpu_dat_out are loaded from the request.
  - Without a handshake, an idle read is loaded: cpu_addr=IDLE_ADDR, cpu_rw=1.
  - Address and rw therefore stay stable across the previous falling edge; the responder latches on negedge M2.
- cpu_dat_oe:
  - Set on the HI cnt==0 transition of a write cycle.
  - Held through the M2 falling edge.
  - Cleared at the next bus update (LO cnt==0 → visible LO cnt==1).
  - Never high on read or idle cycles.
- Read sampling: cpu_dat_in is captured into rsp_rdat on the last HI clk (HI cnt==T_HI-1).
- rsp_valid:
  - Pulses one clk coincident with M2 falling (first LO clk) for every accepted request, read or write.
  - Idle cycles produce no rsp_valid.
  - rsp_rdat is 0 for writes.
- Back-to-back: when req_valid is held, successive requests fill consecutive M2 cycles with no idle gap. The rsp_valid pulse for request N and the req_ready for request N+1 occur on the same clk.
- cyc_cnt increments on every LO→HI transition.
- Width rules: all counters unsigned; cnt width is clog2(max(T_LO,T_HI)).

Decomposition:
- Shared package holds bus_phase_t enum {PH_LO, PH_HI} and the request/response struct typedefs (addr 16, dat 8, rw 1).
- One natural sub-module: m2_phase_gen, owning the phase FSM, cnt, m2 and cyc_cnt, with phase/cnt strobes exported.
- Transaction latching and response logic stay in the top.

Test Plan:
- Reset release → m2=0, cpu_addr=FFFF, cpu_rw=1, cpu_dat_oe=0; first m2 rise exactly T_LO=14 clks after release; cyc_cnt=1 after that rise.
- Write 5800←0x12 → cpu_addr=5800 and cpu_rw=0 from LO cnt 1; cpu_dat_out=0x12 with oe high from HI start through M2 fall; rsp_valid pulse at the fall, rsp_rdat=0.
- Read 5802 with cpu_dat_in=0xA5 during HI → rsp_valid with rsp_rdat=0xA5 on the first LO clk; cpu_dat_oe stays 0.
- req_valid held for three writes (8000←01, 8001←02, 8002←03) → three consecutive 28-clk M2 cycles, no idle cycle between, three rsp_valid pulses spaced 28 clks apart.
- No requests for 10 cycles → 10 idle reads at FFFF, no rsp_valid, cyc_cnt advances by 10.
- map_rst asserted at HI cnt 5 of a write → next clk m2=0, cpu_dat_oe=0, cpu_rw=1, no rsp_valid; normal cycling resumes after release.

Source files
------------

// File: rtl/cpu_bus_master_pkg.sv
// Shared types and helpers for the cartridge CPU bus initiator.
package cpu_bus_master_pkg;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } bus_phase_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  dat;
    } bus_req_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] rdat;
    } bus_rsp_t;

    // Width of the phase counter: enough to hold max(t_lo, t_hi)-1.
    function automatic int unsigned cnt_width(input int unsigned t_lo, input int unsigned t_hi);
        int unsigned m;
        m = (t_lo > t_hi) ? t_lo : t_hi;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cpu_bus_master_m2_phase_gen.sv
// M2 phase generator: LO/HI phase counter, registered m2 and M2 rise counter.
module m2_phase_gen
    import cpu_bus_master_pkg::*;
#(
    parameter int unsigned T_LO  = 14,
    parameter int unsigned T_HI  = 14,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        map_rst,
    output logic        m2,
    output logic [31:0] cyc_cnt,
    output logic        lo_start_c,
    output logic        lo_last_c,
    output logic        hi_last_c
);

    bus_phase_t       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m2_q, m2_d;
    logic [31:0]      cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q + CNT_W'(1);
        cyc_cnt_d = cyc_cnt_q;
        case (phase_q)
            PH_LO: begin
                if (cnt_q == CNT_W'(T_LO - 1)) begin
                    phase_d   = PH_HI;
                    cnt_d     = '0;
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                end
            end
            PH_HI: begin
                if (cnt_q == CNT_W'(T_HI - 1)) begin
                    phase_d = PH_LO;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = PH_LO;
                cnt_d   = '0;
            end
        endcase
        m2_d = (phase_d == PH_HI);
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            phase_q   <= PH_LO;
            cnt_q     <= '0;
            m2_q      <= 1'b0;
            cyc_cnt_q <= 32'd0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            m2_q      <= m2_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign m2         = m2_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign lo_start_c = (phase_q == PH_LO) && (cnt_q == '0);
    assign lo_last_c  = (phase_q == PH_LO) && (cnt_q == CNT_W'(T_LO - 1));
    assign hi_last_c  = (phase_q == PH_HI) && (cnt_q == CNT_W'(T_HI - 1));

endmodule

// File: rtl/cpu_bus_master.sv
// Cartridge CPU bus initiator: one request per M2 cycle, idle reads otherwise.
module cpu_bus_master
    import cpu_bus_master_pkg::*;
#(
    parameter int unsigned T_LO      = 14,
    parameter int unsigned T_HI      = 14,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        map_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdat,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdat,
    output logic        m2,
    output logic [15:0] cpu_addr,
    output logic        cpu_rw,
    output logic [7:0]  cpu_dat_out,
    output logic        cpu_dat_oe,
    input  logic [7:0]  cpu_dat_in,
    output logic [31:0] cyc_cnt
);

    localparam int unsigned CNT_W    = cnt_width(T_LO, T_HI);
    localparam bus_req_t    IDLE_BUS = '{rw: 1'b1, addr: IDLE_ADDR, dat: 8'h00};

    logic     lo_start_c, lo_last_c, hi_last_c;
    logic     hs_c;
    bus_req_t bus_q, bus_d;
    logic     busy_q, busy_d;
    logic     oe_q, oe_d;
    bus_rsp_t rsp_q, rsp_d;

    m2_phase_gen #(
        .T_LO  (T_LO),
        .T_HI  (T_HI),
        .CNT_W (CNT_W)
    ) u_phase (
        .clk        (clk),
        .map_rst    (map_rst),
        .m2         (m2),
        .cyc_cnt    (cyc_cnt),
        .lo_start_c (lo_start_c),
        .lo_last_c  (lo_last_c),
        .hi_last_c  (hi_last_c)
    );

    assign req_ready = lo_start_c & ~map_rst;
    assign hs_c      = req_valid & req_ready;

    // Bus update on the first LO clk; driver enable tracks the write data phase.
    always_comb begin
        bus_d        = bus_q;
        busy_d       = busy_q;
        oe_d         = oe_q;
        rsp_d.valid  = 1'b0;
        rsp_d.rdat   = rsp_q.rdat;
        if (lo_start_c) begin
            oe_d = 1'b0;
            if (hs_c) begin
                bus_d  = '{rw: req_rw, addr: req_addr, dat: req_wdat};
                busy_d = 1'b1;
            end else begin
                bus_d  = IDLE_BUS;
                busy_d = 1'b0;
            end
        end
        if (lo_last_c && busy_q && !bus_q.rw) begin
            oe_d = 1'b1;
        end
        // Completion lands on the clk where m2 falls.
        if (hi_last_c && busy_q) begin
            rsp_d.valid = 1'b1;
            rsp_d.rdat  = bus_q.rw ? cpu_dat_in : 8'h00;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            bus_q  <= IDLE_BUS;
            busy_q <= 1'b0;
            oe_q   <= 1'b0;
            rsp_q  <= '0;
        end else begin
            bus_q  <= bus_d;
            busy_q <= busy_d;
            oe_q   <= oe_d;
            rsp_q  <= rsp_d;
        end
    end

    assign cpu_addr    = bus_q.addr;
    assign cpu_rw      = bus_q.rw;
    assign cpu_dat_out = bus_q.dat;
    assign cpu_dat_oe  = oe_q;
    assign rsp_valid   = rsp_q.valid;
    assign rsp_rdat    = rsp_q.rdat;

endmodule
